// File: rtl/rob_pkg.sv
// Shared defaults and pointer helpers for the reorder buffer.
package rob_pkg;

  localparam int ROB_DATA_W = 512;
  localparam int ROB_RAM_W  = 256;
  localparam int ROB_DEPTH  = 4096;

  // Tag is inside [head, tail) when its distance from head is below the occupancy;
  // pointers carry one wrap bit above tag_w so full and empty stay distinct.
  function automatic logic in_window(input logic [31:0] tag, input logic [31:0] head,
                                     input logic [31:0] tail, input logic [31:0] tag_w);
    logic [31:0] tag_mask;
    logic [31:0] ptr_mask;
    logic [31:0] offset;
    logic [31:0] occupied;
    tag_mask = (32'd1 << tag_w) - 32'd1;
    ptr_mask = (32'd1 << (tag_w + 32'd1)) - 32'd1;
    offset   = (tag - head) & tag_mask;
    occupied = (tail - head) & ptr_mask;
    return offset < occupied;
  endfunction

endpackage

// File: rtl/rob_reorder_buf_if.sv
// Allocation, response-write and in-order output signals of the reorder buffer.
interface rob_reorder_buf_if import rob_pkg::*; #(
  parameter int DATA_W = ROB_DATA_W,
  parameter int DEPTH  = ROB_DEPTH
) ();
  localparam int TAG_W = $clog2(DEPTH);

  logic              alloc_req;
  logic              alloc_gnt;
  logic [TAG_W-1:0]  alloc_tag;
  logic              wr_en;
  logic [TAG_W-1:0]  wr_tag;
  logic [DATA_W-1:0] wr_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic [TAG_W:0]    count;
  logic              full;
  logic              empty;
  logic              err_dup;
  logic              err_unalloc;

  modport master (
    output alloc_req, wr_en, wr_tag, wr_data, out_ready,
    input  alloc_gnt, alloc_tag, out_valid, out_data, out_tag, count, full, empty,
           err_dup, err_unalloc
  );

  modport slave (
    input  alloc_req, wr_en, wr_tag, wr_data, out_ready,
    output alloc_gnt, alloc_tag, out_valid, out_data, out_tag, count, full, empty,
           err_dup, err_unalloc
  );
endinterface

// File: rtl/rob_ram_bank.sv
// One simple dual-port storage bank: synchronous write, registered read, no reset on contents.
module rob_ram_bank #(
  parameter int W     = 256,
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/rob_reorder_buf.sv
// Reorder buffer: hands out sequential tags, accepts responses by tag in any order,
// and streams payloads out strictly in allocation order.
module rob_reorder_buf import rob_pkg::*; #(
  parameter int DATA_W = ROB_DATA_W,
  parameter int RAM_W  = ROB_RAM_W,
  parameter int DEPTH  = ROB_DEPTH
) (
  input logic              clk,
  input logic              rst_n,
  rob_reorder_buf_if.slave bus
);
  localparam int TAG_W  = $clog2(DEPTH);
  localparam int N_BANK = DATA_W / RAM_W;

  logic [TAG_W:0]    tail_q, tail_d, head_q, head_d, count_s;
  logic [TAG_W-1:0]  head_idx_s;
  logic [DEPTH-1:0]  valid_q;
  logic              full_s, alloc_gnt_s, in_win_s, wr_ok_s, issue_s, pop_s;
  logic              rd_pend_q;
  logic [TAG_W-1:0]  rd_tag_q;
  logic [DATA_W-1:0] rd_data_s;
  logic [1:0]        inflight_s, skid_cnt_q, skid_cnt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d, spare_data_q, spare_data_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d, spare_tag_q, spare_tag_d;
  logic              err_dup_q, err_unalloc_q;

  assign count_s     = tail_q - head_q;
  assign full_s      = (count_s == (TAG_W+1)'(DEPTH));
  assign head_idx_s  = head_q[TAG_W-1:0];
  assign alloc_gnt_s = bus.alloc_req && !full_s;
  assign in_win_s    = in_window(32'(bus.wr_tag), 32'(head_q), 32'(tail_q), 32'(TAG_W));
  assign wr_ok_s     = bus.wr_en && in_win_s && !valid_q[bus.wr_tag];
  assign pop_s       = (skid_cnt_q != 2'd0) && bus.out_ready;
  // Occupancy net of this cycle's transfer, so a steady stream keeps one read per cycle.
  assign inflight_s  = {1'b0, rd_pend_q} + skid_cnt_q - {1'b0, pop_s};
  assign issue_s     = valid_q[head_idx_s] && (inflight_s < 2'd2);

  for (genvar b = 0; b < N_BANK; b++) begin : g_bank
    rob_ram_bank #(.W(RAM_W), .DEPTH(DEPTH), .AW(TAG_W)) u_bank (
      .clk     (clk),
      .we_i    (wr_ok_s),
      .waddr_i (bus.wr_tag),
      .wdata_i (bus.wr_data[b*RAM_W +: RAM_W]),
      .re_i    (issue_s),
      .raddr_i (head_idx_s),
      .rdata_o (rd_data_s[b*RAM_W +: RAM_W])
    );
  end

  // Pointer advance and skid FIFO next state; out_* is always the FIFO head register.
  always_comb begin
    tail_d       = tail_q + {{TAG_W{1'b0}}, alloc_gnt_s};
    head_d       = head_q + {{TAG_W{1'b0}}, issue_s};
    skid_cnt_d   = skid_cnt_q;
    out_data_d   = out_data_q;
    out_tag_d    = out_tag_q;
    spare_data_d = spare_data_q;
    spare_tag_d  = spare_tag_q;
    case ({rd_pend_q, pop_s})
      2'b01: begin
        if (skid_cnt_q == 2'd2) begin
          out_data_d = spare_data_q;
          out_tag_d  = spare_tag_q;
          skid_cnt_d = 2'd1;
        end else begin
          skid_cnt_d = 2'd0;
        end
      end
      2'b10: begin
        if (skid_cnt_q == 2'd0) begin
          out_data_d = rd_data_s;
          out_tag_d  = rd_tag_q;
          skid_cnt_d = 2'd1;
        end else begin
          spare_data_d = rd_data_s;
          spare_tag_d  = rd_tag_q;
          skid_cnt_d   = 2'd2;
        end
      end
      2'b11: begin
        out_data_d = rd_data_s;
        out_tag_d  = rd_tag_q;
      end
      default: begin
        skid_cnt_d = skid_cnt_q;
      end
    endcase
  end

  // State registers, entry-valid bits and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tail_q        <= '0;
      head_q        <= '0;
      valid_q       <= '0;
      rd_pend_q     <= 1'b0;
      rd_tag_q      <= '0;
      skid_cnt_q    <= 2'd0;
      out_data_q    <= '0;
      out_tag_q     <= '0;
      spare_data_q  <= '0;
      spare_tag_q   <= '0;
      err_dup_q     <= 1'b0;
      err_unalloc_q <= 1'b0;
    end else begin
      tail_q       <= tail_d;
      head_q       <= head_d;
      rd_pend_q    <= issue_s;
      skid_cnt_q   <= skid_cnt_d;
      out_data_q   <= out_data_d;
      out_tag_q    <= out_tag_d;
      spare_data_q <= spare_data_d;
      spare_tag_q  <= spare_tag_d;
      if (issue_s) begin
        rd_tag_q            <= head_idx_s;
        valid_q[head_idx_s] <= 1'b0;
      end
      if (wr_ok_s) begin
        valid_q[bus.wr_tag] <= 1'b1;
      end
      err_dup_q     <= err_dup_q | (bus.wr_en && in_win_s && valid_q[bus.wr_tag]);
      err_unalloc_q <= err_unalloc_q | (bus.wr_en && !in_win_s);
    end
  end

  assign bus.alloc_gnt   = alloc_gnt_s;
  assign bus.alloc_tag   = tail_q[TAG_W-1:0];
  assign bus.out_valid   = (skid_cnt_q != 2'd0);
  assign bus.out_data    = out_data_q;
  assign bus.out_tag     = out_tag_q;
  assign bus.count       = count_s;
  assign bus.full        = full_s;
  assign bus.empty       = (count_s == '0);
  assign bus.err_dup     = err_dup_q;
  assign bus.err_unalloc = err_unalloc_q;
endmodule
